// File: rtl/parking_pkg.sv
// Shared encodings for the parking-lot sensor path.
// Holds the FSM state codes and the filtered sensor-pair codes {A,B}.
// No logic; imported by the interface, filter and direction FSM.
package parking_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] pair_t;

    // FSM state encoding, visible on the State debug output
    localparam state_t IDLE       = 3'd0;
    localparam state_t IN_A       = 3'd1;
    localparam state_t IN_AB      = 3'd2;
    localparam state_t IN_B       = 3'd3;
    localparam state_t OUT_B      = 3'd4;
    localparam state_t OUT_BA     = 3'd5;
    localparam state_t OUT_A      = 3'd6;
    localparam state_t WAIT_CLEAR = 3'd7;

    // Filtered sensor pair, ordered {A,B}; 1 means beam blocked
    localparam pair_t NONE   = 2'b00;
    localparam pair_t B_ONLY = 2'b01;
    localparam pair_t A_ONLY = 2'b10;
    localparam pair_t BOTH   = 2'b11;

endpackage

// File: rtl/car_direction_detector_if.sv
// Bundle of raw gate sensors in and direction/fault events out.
// Pure wiring; event outputs are registered by the detector.
// No backpressure: events are single-cycle pulses consumed as they occur.
interface car_direction_detector_if;
    import parking_pkg::*;

    logic   SensorA;
    logic   SensorB;
    logic   Enter;
    logic   Exit;
    logic   Fault;
    state_t State;

    // master drives the raw sensors and observes the events
    modport master (output SensorA, output SensorB,
                    input  Enter, input Exit, input Fault, input State);
    // slave is the detector itself
    modport slave  (input  SensorA, input SensorB,
                    output Enter, output Exit, output Fault, output State);

endinterface

// File: rtl/sensor_filter.sv
// Synchronises and debounces one raw, asynchronous beam sensor.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples to a filtered change.
// No backpressure; a sample equal to the filtered value restarts the count.
module sensor_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw_i,
    output logic filt_o
);

    // Counter value at which the next differing sample commits the change
    localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync2_q;
    logic       filt_q,  filt_d;
    logic [7:0] cnt_q,   cnt_d;

    // Debounce decision on the synchronised sample
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q >= LAST_CNT) begin
            filt_d = sync2_q;
            cnt_d  = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Two-flop synchroniser, counter and filtered value registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/car_direction_detector.sv
// Tracks the A/B blocking order of a passing car and emits Enter/Exit/Fault pulses.
// Latency: one registered cycle after the FSM samples the completing filtered pair.
// No backpressure: pulses are single-cycle and must be consumed when high.
module car_direction_detector
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    car_direction_detector_if.slave  bus
);

    logic   filt_a, filt_b;
    pair_t  pair;
    state_t state_q, state_d;
    logic   enter_q, enter_d;
    logic   exit_q,  exit_d;
    logic   fault_q, fault_d;

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
        .Clock  (Clock),
        .Reset  (Reset),
        .raw_i  (bus.SensorA),
        .filt_o (filt_a)
    );

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
        .Clock  (Clock),
        .Reset  (Reset),
        .raw_i  (bus.SensorB),
        .filt_o (filt_b)
    );

    assign pair = {filt_a, filt_b};

    // Direction FSM; unlisted pairs hold, so a steady pattern never re-fires
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pair == A_ONLY)      state_d = IN_A;
                else if (pair == B_ONLY) state_d = OUT_B;
                else if (pair == BOTH)   begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            IN_A: begin
                if (pair == BOTH)        state_d = IN_AB;
                else if (pair == NONE)   state_d = IDLE;   // backed out, no count
                else if (pair == B_ONLY) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            IN_AB: begin
                if (pair == B_ONLY)      state_d = IN_B;
                else if (pair == A_ONLY) state_d = IN_A;
                else if (pair == NONE)   begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            IN_B: begin
                if (pair == NONE)        begin state_d = IDLE; enter_d = 1'b1; end
                else if (pair == BOTH)   state_d = IN_AB;
                else if (pair == A_ONLY) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            OUT_B: begin
                if (pair == BOTH)        state_d = OUT_BA;
                else if (pair == NONE)   state_d = IDLE;
                else if (pair == A_ONLY) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            OUT_BA: begin
                if (pair == A_ONLY)      state_d = OUT_A;
                else if (pair == B_ONLY) state_d = OUT_B;
                else if (pair == NONE)   begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            OUT_A: begin
                if (pair == NONE)        begin state_d = IDLE; exit_d = 1'b1; end
                else if (pair == BOTH)   state_d = OUT_BA;
                else if (pair == B_ONLY) begin state_d = WAIT_CLEAR; fault_d = 1'b1; end
            end
            WAIT_CLEAR: begin
                if (pair == NONE)        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered event pulses; reset drops any partial car
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            fault_q <= fault_d;
        end
    end

    assign bus.Enter = enter_q;
    assign bus.Exit  = exit_q;
    assign bus.Fault = fault_q;
    assign bus.State = state_q;

endmodule

// File: tb/tb_car_direction_detector.sv
// Randomised-hold scenario bench for car_direction_detector with a reference model.
// Model: sliding window of synchronised samples plus a transition table.
// Inputs driven #1 after posedge, outputs sampled #1 after posedge.
module tb_car_direction_detector;

    localparam int N = 4;

    logic Clock = 1'b0;
    logic Reset;

    car_direction_detector_if bus ();

    car_direction_detector #(.DEBOUNCE_CYCLES(N)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    logic [2:0] nxt [8][4];
    int         evt [8][4];     // 0 none, 1 enter, 2 exit, 3 fault
    logic       m_s1a, m_s2a, m_s1b, m_s2b, m_fa, m_fb;
    bit         win_a[$], win_b[$];
    logic [2:0] m_state;
    int         m_ev;
    logic [5:0] expv;
    logic [5:0] obs;

    assign obs = {bus.Enter, bus.Exit, bus.Fault, bus.State};

    task automatic tset(input int s, input int p, input int n, input int e);
        nxt[s][p] = 3'(n);
        evt[s][p] = e;
    endtask

    task automatic build_table();
        for (int s = 0; s < 8; s++)
            for (int p = 0; p < 4; p++) begin
                nxt[s][p] = 3'(s);
                evt[s][p] = 0;
            end
        // states: 0 idle,1 in_a,2 in_ab,3 in_b,4 out_b,5 out_ba,6 out_a,7 wait; pairs {A,B}
        tset(0, 2, 1, 0); tset(0, 1, 4, 0); tset(0, 3, 7, 3);
        tset(1, 3, 2, 0); tset(1, 0, 0, 0); tset(1, 1, 7, 3);
        tset(2, 1, 3, 0); tset(2, 2, 1, 0); tset(2, 0, 7, 3);
        tset(3, 0, 0, 1); tset(3, 3, 2, 0); tset(3, 2, 7, 3);
        tset(4, 3, 5, 0); tset(4, 0, 0, 0); tset(4, 2, 7, 3);
        tset(5, 2, 6, 0); tset(5, 1, 4, 0); tset(5, 0, 7, 3);
        tset(6, 0, 0, 2); tset(6, 3, 5, 0); tset(6, 1, 7, 3);
        tset(7, 0, 0, 0);
    endtask

    // Filter flips once the last N synchronised samples all disagree with it
    function automatic bit settled(bit q[$], logic f);
        if (q.size() != N) return 1'b0;
        foreach (q[i]) if (q[i] == f) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle, advance the model at the edge, settle before sampling
    task automatic step(input logic a, input logic b, input logic rst);
        int p;
        bus.SensorA = a;
        bus.SensorB = b;
        Reset       = rst;
        @(posedge Clock);
        if (rst) begin
            m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0; m_fa = 0; m_fb = 0;
            win_a.delete(); win_b.delete();
            m_state = 3'd0;
            m_ev    = 0;
        end else begin
            p       = {30'd0, m_fa, m_fb};
            m_ev    = evt[m_state][p];
            m_state = nxt[m_state][p];
            win_a.push_back(m_s2a); if (win_a.size() > N) void'(win_a.pop_front());
            win_b.push_back(m_s2b); if (win_b.size() > N) void'(win_b.pop_front());
            if (settled(win_a, m_fa)) m_fa = ~m_fa;
            if (settled(win_b, m_fb)) m_fb = ~m_fb;
            m_s2a = m_s1a; m_s1a = a;
            m_s2b = m_s1b; m_s1b = b;
        end
        expv = {m_ev == 1, m_ev == 2, m_ev == 3, m_state};
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b1);
            vectors++;
            if (obs !== 6'd0 || obs !== expv) begin
                miscompares++;
                $display("FAIL reset_hold k=%0d got=%b want=%b", k, obs, 6'd0);
            end
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            vectors++;
            if (obs !== 6'd0 || obs !== expv) begin
                miscompares++;
                $display("FAIL reset_release k=%0d got=%b want=%b", k, obs, 6'd0);
            end
        end
    endtask

    task automatic test_entry();
        logic [1:0] seq   [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [2:0] endst [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        int enters = 0, others = 0, lat = -1, len;
        for (int ph = 0; ph < 5; ph++) begin
            len = $urandom_range(8, 12);
            for (int k = 1; k <= len; k++) begin
                step(seq[ph][1], seq[ph][0], 1'b0);
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL entry_cycle ph=%0d k=%0d got=%b want=%b", ph, k, obs, expv);
                end
                if (bus.Enter === 1'b1) begin enters++; if (ph == 4) lat = k; end
                if (bus.Exit === 1'b1 || bus.Fault === 1'b1) others++;
            end
            vectors++;
            if (bus.State !== endst[ph]) begin
                miscompares++;
                $display("FAIL entry_state ph=%0d got=%0d want=%0d", ph, bus.State, endst[ph]);
            end
        end
        vectors++;
        if (enters !== 1) begin miscompares++; $display("FAIL entry_count got=%0d want=1", enters); end
        vectors++;
        if (lat !== 7) begin miscompares++; $display("FAIL entry_latency got=%0d want=7", lat); end
        vectors++;
        if (others !== 0) begin miscompares++; $display("FAIL entry_other_pulses got=%0d want=0", others); end
    endtask

    task automatic test_exit_x3();
        logic [1:0] seq   [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [2:0] endst [4] = '{3'd4, 3'd5, 3'd6, 3'd0};
        int exits = 0, others = 0, len;
        for (int r = 0; r < 3; r++)
            for (int ph = 0; ph < 4; ph++) begin
                len = $urandom_range(8, 12);
                for (int k = 1; k <= len; k++) begin
                    step(seq[ph][1], seq[ph][0], 1'b0);
                    vectors++;
                    if (obs !== expv) begin
                        miscompares++;
                        $display("FAIL exit_cycle r=%0d ph=%0d k=%0d got=%b want=%b", r, ph, k, obs, expv);
                    end
                    if (bus.Exit === 1'b1) exits++;
                    if (bus.Enter === 1'b1 || bus.Fault === 1'b1) others++;
                end
                vectors++;
                if (bus.State !== endst[ph]) begin
                    miscompares++;
                    $display("FAIL exit_state r=%0d ph=%0d got=%0d want=%0d", r, ph, bus.State, endst[ph]);
                end
            end
        vectors++;
        if (exits !== 3) begin miscompares++; $display("FAIL exit_count got=%0d want=3", exits); end
        vectors++;
        if (others !== 0) begin miscompares++; $display("FAIL exit_other_pulses got=%0d want=0", others); end
    endtask

    task automatic test_backout();
        logic [1:0] seq   [4] = '{2'b10, 2'b11, 2'b10, 2'b00};
        logic [2:0] endst [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        int pulses = 0, len;
        for (int ph = 0; ph < 4; ph++) begin
            len = $urandom_range(8, 12);
            for (int k = 1; k <= len; k++) begin
                step(seq[ph][1], seq[ph][0], 1'b0);
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL backout_cycle ph=%0d k=%0d got=%b want=%b", ph, k, obs, expv);
                end
                if (obs[5:3] !== 3'b000) pulses++;
            end
            vectors++;
            if (bus.State !== endst[ph]) begin
                miscompares++;
                $display("FAIL backout_state ph=%0d got=%0d want=%0d", ph, bus.State, endst[ph]);
            end
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL backout_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_fault_recovery();
        logic [1:0] seq   [8] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [2:0] endst [8] = '{3'd0, 3'd7, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        int faults = 0, enters = 0, exits = 0, len;
        for (int ph = 0; ph < 8; ph++) begin
            len = $urandom_range(8, 12);
            for (int k = 1; k <= len; k++) begin
                step(seq[ph][1], seq[ph][0], 1'b0);
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL fault_cycle ph=%0d k=%0d got=%b want=%b", ph, k, obs, expv);
                end
                if (bus.Fault === 1'b1) faults++;
                if (bus.Enter === 1'b1) enters++;
                if (bus.Exit === 1'b1) exits++;
            end
            vectors++;
            if (bus.State !== endst[ph]) begin
                miscompares++;
                $display("FAIL fault_state ph=%0d got=%0d want=%0d", ph, bus.State, endst[ph]);
            end
        end
        vectors++;
        if (faults !== 1) begin miscompares++; $display("FAIL fault_count got=%0d want=1", faults); end
        vectors++;
        if (enters !== 1 || exits !== 0) begin
            miscompares++;
            $display("FAIL fault_recover_enter got=%0d/%0d want=1/0", enters, exits);
        end
    endtask

    task automatic test_glitch_and_reset();
        int pulses = 0;
        // short raw A pulse must never reach the FSM
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            vectors++;
            if (obs !== 6'd0 || obs !== expv) begin
                miscompares++;
                $display("FAIL glitch_cycle k=%0d got=%b want=%b", k, obs, 6'd0);
            end
        end
        // walk into IN_AB, then reset mid-car
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
        vectors++;
        if (bus.State !== 3'd2 || obs !== expv) begin
            miscompares++;
            $display("FAIL pre_reset_state got=%0d want=2", bus.State);
        end
        step(1'b0, 1'b0, 1'b1);
        vectors++;
        if (obs !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_state got=%b want=%b", obs, 6'd0);
        end
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b0, 1'b0);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL post_reset_cycle k=%0d got=%b want=%b", k, obs, expv);
            end
            if (obs[5:3] !== 3'b000) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL post_reset_pulses got=%0d want=0", pulses); end
    endtask

    // Random levels and hold lengths, including sub-debounce glitches
    task automatic test_random();
        logic a, b;
        int len;
        for (int ph = 0; ph < 60; ph++) begin
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 12);
            for (int k = 0; k < len; k++) begin
                step(a, b, 1'b0);
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL random_cycle ph=%0d k=%0d got=%b want=%b", ph, k, obs, expv);
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_drain k=%0d got=%b want=%b", k, obs, expv);
            end
        end
    endtask

    initial begin
        bus.SensorA = 1'b0;
        bus.SensorB = 1'b0;
        Reset       = 1'b1;
        m_state     = 3'd0;
        m_ev        = 0;
        build_table();
        test_reset();
        test_entry();
        test_exit_x3();
        test_backout();
        test_fault_recovery();
        test_glitch_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
